// File: rtl/uio_port_arbiter_if.sv
// rtl/uio_port_arbiter_if.sv - requester and pad bundle shared by uio_port_arbiter and its users
interface uio_port_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    dir;
  logic [NREQ-1:0]    last;
  logic [NREQ*DW-1:0] wdata;
  logic [DW-1:0]      uio_in;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      uio_out;
  logic [DW-1:0]      uio_oe;
  logic [DW-1:0]      rdata;
  logic               rvalid;
  logic               busy;

  // requester side plus the pad input path
  modport master (
    output req, dir, last, wdata, uio_in,
    input  gnt, uio_out, uio_oe, rdata, rvalid, busy
  );

  // arbiter side, sole driver of the pad outputs
  modport slave (
    input  req, dir, last, wdata, uio_in,
    output gnt, uio_out, uio_oe, rdata, rvalid, busy
  );
endinterface

// File: rtl/uio_port_arbiter.sv
// rtl/uio_port_arbiter.sv - round-robin burst sequencer owning the uio pad bank
module uio_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 8
) (
  input logic               clk,
  input logic               reset,
  uio_port_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] owner_inc;
  logic [IW-1:0] win;
  logic          found;
  logic [7:0]    cnt;
  logic [7:0]    cnt_inc;
  logic          wr;
  logic          burst_end;
  logic [DW-1:0] owner_wdata;

  // rotating-priority search: first asserted req at or after ptr wins
  always_comb begin
    found = 1'b0;
    win   = ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req[IW'((int'(ptr) + k) % NREQ)]) begin
        found = 1'b1;
        win   = IW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  // owner-relative helpers: next pointer, beat count, end-of-burst, write data
  always_comb begin
    owner_inc   = (int'(owner) == NREQ - 1) ? '0 : owner + IW'(1);
    cnt_inc     = cnt + 8'd1;
    burst_end   = !bus.req[owner] || bus.last[owner] || (cnt_inc == 8'(MAX_BURST));
    owner_wdata = bus.wdata[int'(owner)*DW +: DW];
  end

  // sequencer: pads default to idle each cycle, so only a beat in the previous cycle drives them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      wr          <= 1'b0;
      bus.gnt     <= '0;
      bus.uio_out <= '0;
      bus.uio_oe  <= '0;
      bus.rdata   <= '0;
      bus.rvalid  <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.uio_out <= '0;
      bus.uio_oe  <= '0;
      bus.rvalid  <= 1'b0;
      case (state)
        GRANT: begin
          if (bus.req[owner]) begin
            cnt <= cnt_inc;
            if (wr) begin
              bus.uio_out <= owner_wdata;
              bus.uio_oe  <= '1;
            end else begin
              bus.rdata  <= bus.uio_in;
              bus.rvalid <= 1'b1;
            end
          end
          if (burst_end) begin
            state   <= TURN;
            bus.gnt <= '0;
            ptr     <= owner_inc;
          end
          bus.busy <= 1'b1;
        end
        default: begin
          if (found) begin
            state    <= GRANT;
            owner    <= win;
            wr       <= bus.dir[win];
            cnt      <= '0;
            bus.gnt  <= NREQ'(1) << win;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.gnt  <= '0;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
